card_authorizer: RTL and testbench

//   Card-side counterpart of vending_machine: holds the inserted card's balance, drives CARD_IN,

---
 rtl/card_authorizer_if.sv | 30 +++
 rtl/card_authorizer.sv | 158 +++++++++++++++
 tb/tb_card_authorizer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/card_authorizer_if.sv
// Signals between the card reader, the keypad/vending_machine snoop taps and card_authorizer.
// slave = card_authorizer side, master = the environment driving it.
interface card_authorizer_if #(
   parameter int unsigned BalW = 8
);
   logic            card_swipe;
   logic [BalW-1:0] card_bal;
   logic            key_press;
   logic [2:0]      cost;
   logic            invalid_sel;
   logic            vend;
   logic            failed_tran;
   logic            card_in;
   logic            valid_tran;
   logic [BalW-1:0] balance;
   logic            declined;
   logic            refund;
   logic            busy;
   logic [7:0]      txn_count;

   modport slave (
      input  card_swipe, card_bal, key_press, cost, invalid_sel, vend, failed_tran,
      output card_in, valid_tran, balance, declined, refund, busy, txn_count
   );

   modport master (
      output card_swipe, card_bal, key_press, cost, invalid_sel, vend, failed_tran,
      input  card_in, valid_tran, balance, declined, refund, busy, txn_count
   );
endinterface

// File: rtl/card_authorizer.sv
// Card-side authorizer for vending_machine: holds the card balance, approves/declines the
// selected price, debits on approval and refunds when no vend follows.
// Optional: define CARD_AUTH_TXN_COUNT_EN to keep a saturating count of successful vends.
module card_authorizer #(
   parameter int unsigned BalW       = 8,
   parameter int unsigned AuthLat    = 2,
   parameter int unsigned KeyTimeout = 5,
   parameter int unsigned VendWait   = 8
) (
   input logic              clk,
   input logic              reset,
   card_authorizer_if.slave bus
);
   localparam int unsigned MaxCntA = (KeyTimeout > VendWait) ? KeyTimeout : VendWait;
   localparam int unsigned MaxCnt  = (MaxCntA > AuthLat) ? MaxCntA : AuthLat;
   localparam int unsigned TmrW    = $clog2(MaxCnt + 1);

   typedef enum logic [2:0] {
      StIdle,
      StKey1,
      StKey2,
      StSample,
      StAuth,
      StConfirm
   } state_e;

   state_e            state_q, state_d;
   logic [TmrW-1:0]   timer_q, timer_d;
   logic [BalW-1:0]   balance_q, balance_d;
   logic [2:0]        cost_q, cost_d;
   logic              card_in_q, card_in_d;
   logic              valid_q, valid_d;
   logic              declined_q, declined_d;
   logic              refund_q, refund_d;
   logic              busy_q, busy_d;

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      balance_d  = balance_q;
      cost_d     = cost_q;
      card_in_d  = 1'b0;
      valid_d    = 1'b0;
      declined_d = 1'b0;
      refund_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.card_swipe) begin
               balance_d = bus.card_bal;
               card_in_d = 1'b1;
               timer_d   = '0;
               state_d   = StKey1;
            end
         end
         StKey1, StKey2: begin
            if (bus.key_press) begin
               timer_d = '0;
               state_d = (state_q == StKey1) ? StKey2 : StSample;
            end else if (timer_q == TmrW'(KeyTimeout - 1)) begin
               state_d = StIdle;
            end else begin
               timer_d = timer_q + TmrW'(1);
            end
         end
         StSample: begin
            if (bus.invalid_sel) begin
               state_d = StIdle;
            end else begin
               cost_d  = bus.cost;
               timer_d = '0;
               state_d = StAuth;
            end
         end
         StAuth: begin
            if (timer_q == TmrW'(AuthLat - 1)) begin
               timer_d = '0;
               // Debit only after the compare, so the balance can never wrap.
               if (balance_q >= BalW'(cost_q)) begin
                  valid_d   = 1'b1;
                  balance_d = balance_q - BalW'(cost_q);
                  state_d   = StConfirm;
               end else begin
                  declined_d = 1'b1;
                  state_d    = StIdle;
               end
            end else begin
               timer_d = timer_q + TmrW'(1);
            end
         end
         StConfirm: begin
            if (bus.vend) begin
               state_d = StIdle;
            end else if (bus.failed_tran || (timer_q == TmrW'(VendWait - 1))) begin
               balance_d = balance_q + BalW'(cost_q);
               refund_d  = 1'b1;
               state_d   = StIdle;
            end else begin
               timer_d = timer_q + TmrW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         balance_q  <= '0;
         cost_q     <= '0;
         card_in_q  <= 1'b0;
         valid_q    <= 1'b0;
         declined_q <= 1'b0;
         refund_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         balance_q  <= balance_d;
         cost_q     <= cost_d;
         card_in_q  <= card_in_d;
         valid_q    <= valid_d;
         declined_q <= declined_d;
         refund_q   <= refund_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.card_in    = card_in_q;
   assign bus.valid_tran = valid_q;
   assign bus.balance    = balance_q;
   assign bus.declined   = declined_q;
   assign bus.refund     = refund_q;
   assign bus.busy       = busy_q;

`ifdef CARD_AUTH_TXN_COUNT_EN
   logic       vend_ok;
   logic [7:0] txn_q;

   // VEND takes priority over FAILED_TRAN, so any vend seen in CONFIRM is a success.
   assign vend_ok = (state_q == StConfirm) && bus.vend;

   always_ff @(posedge clk) begin
      if (reset) begin
         txn_q <= 8'd0;
      end else if (vend_ok && (txn_q != 8'hff)) begin
         txn_q <= txn_q + 8'd1;
      end
   end

   assign bus.txn_count = txn_q;
`else
   assign bus.txn_count = 8'd0;
`endif
endmodule

// File: tb/tb_card_authorizer.sv
// Self-checking bench for card_authorizer: fixed vector table, randomized transactions against
// a transaction-level model, and hand sequences for timeouts and mid-transaction reset.
module tb_card_authorizer;
   localparam int unsigned AuthLat    = 2;
   localparam int unsigned KeyTimeout = 5;
   localparam int unsigned VendWait   = 8;
`ifdef CARD_AUTH_TXN_COUNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   card_authorizer_if #(.BalW(8)) bus ();

   card_authorizer #(
      .BalW       (8),
      .AuthLat    (AuthLat),
      .KeyTimeout (KeyTimeout),
      .VendWait   (VendWait)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] bal;
      logic [2:0] cost;
      bit         inval;
      int         mode;     // 0 vend, 1 failed_tran, 2 nothing, 3 vend+failed_tran
      int         dly;      // confirm cycles waited before the mode stimulus
      bit         e_valid;
      bit         e_decl;
      bit         e_refund;
      logic [7:0] e_mid;    // balance shown with VALID_TRAN
      logic [7:0] e_final;
      bit         e_vend;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_card_in, n_valid, n_declined, n_refund;
   int valid_cyc, sample_cyc;
   logic [7:0] bal_at_valid;
   int txn_model = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one clock; observe outputs 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.card_in) n_card_in++;
      if (bus.valid_tran) begin
         n_valid++;
         valid_cyc    = cyc;
         bal_at_valid = bus.balance;
      end
      if (bus.declined) n_declined++;
      if (bus.refund) n_refund++;
   endtask

   task automatic clear_obs();
      n_card_in  = 0;
      n_valid    = 0;
      n_declined = 0;
      n_refund   = 0;
      valid_cyc  = -1;
      bal_at_valid = 8'd0;
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({bus.card_in, bus.valid_tran, bus.balance, bus.declined, bus.refund,
                  bus.busy, bus.txn_count});
   endfunction

   task automatic run_txn(input vec_t v, input string tag);
      clear_obs();
      bus.card_bal   = v.bal;
      bus.card_swipe = 1'b1;
      step();
      bus.card_swipe = 1'b0;
      bus.card_bal   = ~v.bal;
      check({tag, " busy_after_swipe"}, 32'(bus.busy), 32'd1);
      step();
      bus.key_press = 1'b1; step(); bus.key_press = 1'b0;
      step();
      bus.key_press = 1'b1; step(); bus.key_press = 1'b0;
      // Now in the sample cycle: present price / selection validity.
      bus.cost        = v.cost;
      bus.invalid_sel = v.inval;
      step();
      sample_cyc      = cyc;
      bus.cost        = ~v.cost;
      bus.invalid_sel = 1'b0;
      for (int i = 0; i < int'(AuthLat) + 3 && n_valid == 0 && n_declined == 0; i++) step();
      if (n_valid != 0) begin
         repeat (v.dly) step();
         bus.vend        = (v.mode == 0) || (v.mode == 3);
         bus.failed_tran = (v.mode == 1) || (v.mode == 3);
         step();
         bus.vend        = 1'b0;
         bus.failed_tran = 1'b0;
      end
      repeat (VendWait + 2) step();

      if (v.e_vend && txn_model < 255) txn_model++;
      check({tag, " card_in"}, n_card_in, 1);
      check({tag, " valid_tran"}, n_valid, 32'(v.e_valid));
      check({tag, " declined"}, n_declined, 32'(v.e_decl));
      check({tag, " refund"}, n_refund, 32'(v.e_refund));
      check({tag, " balance"}, 32'(bus.balance), 32'(v.e_final));
      check({tag, " busy_end"}, 32'(bus.busy), 32'd0);
      check({tag, " txn_count"}, 32'(bus.txn_count), CntEn ? txn_model : 0);
      if (v.e_valid) begin
         check({tag, " auth_latency"}, valid_cyc - sample_cyc, AuthLat);
         check({tag, " balance_at_valid"}, 32'(bal_at_valid), 32'(v.e_mid));
      end
   endtask

   // Outcome computed straight from the transaction rules.
   function automatic vec_t model(input logic [7:0] bal, input logic [2:0] cost, input bit inval,
                                  input int mode, input int dly);
      vec_t r;
      int approve, vended;
      r.bal = bal; r.cost = cost; r.inval = inval; r.mode = mode; r.dly = dly;
      approve    = (!inval && int'(bal) >= int'(cost)) ? 1 : 0;
      vended     = (approve == 1 && (mode == 0 || mode == 3) && dly < int'(VendWait)) ? 1 : 0;
      r.e_valid  = (approve == 1);
      r.e_decl   = !inval && (approve == 0);
      r.e_refund = (approve == 1) && (vended == 0);
      r.e_mid    = 8'(int'(bal) - int'(cost));
      r.e_final  = (vended == 1) ? 8'(int'(bal) - int'(cost)) : bal;
      r.e_vend   = (vended == 1);
      return r;
   endfunction

   vec_t vecs [12];
   vec_t rv;

   initial begin
      bus.card_swipe  = 1'b0;
      bus.card_bal    = 8'd0;
      bus.key_press   = 1'b0;
      bus.cost        = 3'd0;
      bus.invalid_sel = 1'b0;
      bus.vend        = 1'b0;
      bus.failed_tran = 1'b0;
      clear_obs();

      // Reset with a swipe pending: reset must win.
      reset          = 1'b1;
      bus.card_swipe = 1'b1;
      bus.card_bal   = 8'haa;
      repeat (3) step();
      check("reset_outputs", all_outs(), 32'd0);
      bus.card_swipe = 1'b0;
      reset          = 1'b0;
      step();
      check("post_reset_outputs", all_outs(), 32'd0);

      vecs[0]  = '{8'd10,  3'd3, 1'b0, 0, 2, 1'b1, 1'b0, 1'b0, 8'd7,   8'd7,   1'b1};
      vecs[1]  = '{8'd2,   3'd5, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd2,   1'b0};
      vecs[2]  = '{8'd5,   3'd5, 1'b0, 2, 0, 1'b1, 1'b0, 1'b1, 8'd0,   8'd5,   1'b0};
      vecs[3]  = '{8'd9,   3'd3, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd9,   1'b0};
      vecs[4]  = '{8'd4,   3'd0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 8'd4,   8'd4,   1'b1};
      vecs[5]  = '{8'd0,   3'd0, 1'b0, 1, 3, 1'b1, 1'b0, 1'b1, 8'd0,   8'd0,   1'b0};
      vecs[6]  = '{8'd6,   3'd7, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd6,   1'b0};
      vecs[7]  = '{8'd7,   3'd7, 1'b0, 0, 7, 1'b1, 1'b0, 1'b0, 8'd0,   8'd0,   1'b1};
      vecs[8]  = '{8'd7,   3'd2, 1'b0, 0, 8, 1'b1, 1'b0, 1'b1, 8'd5,   8'd7,   1'b0};
      vecs[9]  = '{8'd200, 3'd7, 1'b0, 3, 4, 1'b1, 1'b0, 1'b0, 8'd193, 8'd193, 1'b1};
      vecs[10] = '{8'd3,   3'd4, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd3,   1'b0};
      vecs[11] = '{8'd255, 3'd7, 1'b0, 1, 7, 1'b1, 1'b0, 1'b1, 8'd248, 8'd255, 1'b0};

      foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 60; i++) begin
         rv = model(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(0, 255)),
                    3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, VendWait + 1)));
         run_txn(rv, $sformatf("rnd%0d", i));
      end

      // Keypad timeout in KEY1.
      clear_obs();
      bus.card_bal = 8'd20; bus.card_swipe = 1'b1; step(); bus.card_swipe = 1'b0;
      repeat (KeyTimeout - 1) step();
      check("key1_timeout_minus1_busy", 32'(bus.busy), 32'd1);
      step();
      check("key1_timeout_busy", 32'(bus.busy), 32'd0);

      // Keypad timeout in KEY2 with a swipe that must be ignored.
      bus.card_swipe = 1'b1; step(); bus.card_swipe = 1'b0;
      bus.key_press = 1'b1; step(); bus.key_press = 1'b0;
      bus.card_bal = 8'd99; bus.card_swipe = 1'b1; step(); bus.card_swipe = 1'b0;
      repeat (KeyTimeout - 2) step();
      check("key2_timeout_minus1_busy", 32'(bus.busy), 32'd1);
      step();
      check("key2_timeout_busy", 32'(bus.busy), 32'd0);
      check("swipe_in_key2_card_in", n_card_in, 2);
      check("swipe_in_key2_balance", 32'(bus.balance), 32'd20);

      // Reset while authorizing: everything clears, no refund.
      clear_obs();
      bus.card_bal = 8'd30; bus.card_swipe = 1'b1; step(); bus.card_swipe = 1'b0;
      bus.key_press = 1'b1; step(); bus.key_press = 1'b0;
      bus.key_press = 1'b1; step(); bus.key_press = 1'b0;
      bus.cost = 3'd3; step();
      step();
      reset = 1'b1; step(); reset = 1'b0;
      check("reset_in_auth_outputs", all_outs(), 32'd0);
      txn_model = 0;
      repeat (VendWait + 2) step();
      check("reset_in_auth_valid", n_valid, 0);
      check("reset_in_auth_refund", n_refund, 0);
      check("reset_in_auth_balance", 32'(bus.balance), 32'd0);

`ifdef CARD_AUTH_TXN_COUNT_EN
      for (int i = 0; i < 257; i++) begin
         rv = model(8'd1, 3'd0, 1'b0, 0, 0);
         run_txn(rv, $sformatf("sat%0d", i));
      end
      check("txn_count_saturated", 32'(bus.txn_count), 32'd255);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
